// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 hex keypad scanner.
// Map index is 4*column + row, rows numbered top to bottom.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } kp_state_t;

    typedef enum {
        NONE,
        SINGLE,
        MULTI
    } scan_kind_t;

    // Entry 15 first: col3 = D,C,B,A ... col0 = 0,7,4,1
    localparam logic [15:0][3:0] KEYMAP = 64'hDCBA_E963_F852_0741;

    function automatic logic [3:0] key_code(input logic [3:0] idx);
        return KEYMAP[idx];
    endfunction

endpackage

// File: rtl/keypad_scan_decode.sv
// Classifies a full 16-bit pressed map as no key, one key or several keys.
// For a single key also returns its hex code.
module keypad_scan_decode
    import keypad_pkg::*;
(
    input  logic [15:0] scan_vec,
    output scan_kind_t  kind,
    output logic [3:0]  code
);

    logic [4:0] ones;
    logic [3:0] idx;

    // Count pressed positions and remember the last one found
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_vec[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end
        end
    end

    // Zero, one or rollover
    always_comb begin
        kind = NONE;
        if (ones == 5'd1)
            kind = SINGLE;
        else if (ones > 5'd1)
            kind = MULTI;
    end

    assign code = key_code(idx);

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader with scan-level debounce.
// Each accepted key is shifted into a 32-bit entry register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clear,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] value
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_N     = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    c;
    logic [15:0]   scan_vec;
    logic          scan_done;

    kp_state_t     state;
    kp_state_t     state_n;
    logic [3:0]    cand;
    logic [3:0]    cand_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] cnt_inc;
    logic          accept;

    scan_kind_t    kind;
    logic [3:0]    code;

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clock) begin
        if (!resetn) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    // Column dwell timer; sample rows at the end of each column window
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dwell     <= '0;
            c         <= '0;
            scan_vec  <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (dwell == DWELL_MAX) begin
                dwell                     <= '0;
                scan_vec[{c, 2'b00} +: 4] <= ~row_s2;
                c                         <= c + 2'd1;
                scan_done                 <= (c == 2'd3);
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    assign col = ~(4'b0001 << c);

    keypad_scan_decode u_decode (
        .scan_vec (scan_vec),
        .kind     (kind),
        .code     (code)
    );

    assign cnt_inc = cnt + 1'b1;

    // Debounce state register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    // Debounce transitions, only advanced once per completed scan
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        accept  = 1'b0;
        if (scan_done) begin
            unique case (state)
                IDLE: begin
                    if (kind == SINGLE) begin
                        cand_n = code;
                        if (DEB_N == CNT_ONE) begin
                            accept  = 1'b1;
                            state_n = PRESSED;
                            cnt_n   = '0;
                        end else begin
                            cnt_n   = CNT_ONE;
                            state_n = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (kind == SINGLE && code == cand) begin
                        if (cnt_inc == DEB_N) begin
                            accept  = 1'b1;
                            state_n = PRESSED;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (kind == NONE) begin
                        if (DEB_N == CNT_ONE) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            state_n = DEB_REL;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                DEB_REL: begin
                    if (kind == NONE) begin
                        if (cnt_inc == DEB_N) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end
                end
            endcase
        end
    end

    // Held flag follows the debounced press
    always_comb begin
        key_held = 1'b0;
        if (state == PRESSED || state == DEB_REL)
            key_held = 1'b1;
    end

    // Key output, strobe and entry shift register; clear beats a shift
    always_ff @(posedge clock) begin
        if (!resetn) begin
            key       <= '0;
            key_valid <= 1'b0;
            value     <= '0;
        end else begin
            key_valid <= accept;
            if (accept)
                key <= cand_n;
            if (clear)
                value <= '0;
            else if (accept)
                value <= {value[27:0], cand_n};
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a switch-matrix keypad model.
// Small scan period and debounce depth keep runs short.
module tb_keypad_scanner;

    logic        clock;
    logic        resetn;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clear;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [31:0] value;

    logic [15:0] pressed;
    int          n_checks;
    int          n_fail;
    int          kv_cnt;
    int          kv_base;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .row       (row),
        .col       (col),
        .clear     (clear),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held),
        .value     (value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Switch matrix: a pressed key shorts its row to its column
    always_comb begin
        row = 4'hF;
        for (int cc = 0; cc < 4; cc++)
            for (int rr = 0; rr < 4; rr++)
                if (pressed[4*cc+rr] && !col[cc])
                    row[rr] = 1'b0;
    end

    // Count strobes using the value held before each edge
    always @(posedge clock)
        if (key_valid)
            kv_cnt <= kv_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic tap(input int idx);
        pressed[idx] = 1'b1;
        wait_n(60);
        pressed[idx] = 1'b0;
        wait_n(70);
    endtask

    // Return on the first negedge after column 0 becomes active again
    task automatic sync_scan();
        int n;
        n = 0;
        while (col !== 4'b0111 && n < 100) begin
            @(negedge clock);
            n++;
        end
        while (col === 4'b0111 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("sync", {31'b0, n < 100}, 32'd1);
    endtask

    int          keys9 [9] = '{0, 4, 8, 1, 5, 9, 2, 6, 10};
    logic [3:0]  ecol;
    logic [3:0]  one;
    int          n;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        kv_cnt   = 0;
        pressed  = '0;
        clear    = 1'b0;
        resetn   = 1'b0;
        one      = 4'b0001;

        // 1: reset values and free-running column walk
        wait_n(3);
        check("rst_col", col, 4'b1110);
        check("rst_value", value, 32'h0);
        check("rst_kv", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        check("rst_key", key, 4'h0);
        resetn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            ecol = ~(one << ((k / 4) % 4));
            check("col_seq", col, ecol);
        end

        // 2: press and hold '5', then release
        kv_base = kv_cnt;
        pressed[5] = 1'b1;
        wait_n(50);
        check("p5_kv", kv_cnt - kv_base, 1);
        check("p5_key", key, 4'h5);
        check("p5_value", value, 32'h5);
        check("p5_held", key_held, 1'b1);
        pressed[5] = 1'b0;
        wait_n(70);
        check("p5_rel", key_held, 1'b0);
        check("p5_kv_rel", kv_cnt - kv_base, 1);

        // 3: bounce '9' so column 2 samples see pressed, open, pressed
        sync_scan();
        kv_base = kv_cnt;
        wait_n(9);
        for (int j = 0; j < 40; j++) begin
            pressed[10] = ((j / 3) % 2 == 0);
            @(negedge clock);
        end
        check("b9_kv_bounce", kv_cnt - kv_base, 0);
        check("b9_held_bounce", key_held, 1'b0);
        pressed[10] = 1'b1;
        wait_n(40);
        check("b9_kv", kv_cnt - kv_base, 1);
        check("b9_key", key, 4'h9);
        check("b9_value", value, 32'h59);
        pressed[10] = 1'b0;
        wait_n(70);

        // 4: nine digits wrap the oldest out, then clear
        kv_base = kv_cnt;
        for (int i = 0; i < 9; i++)
            tap(keys9[i]);
        check("seq_kv", kv_cnt - kv_base, 9);
        check("seq_value", value, 32'h23456789);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clr_value", value, 32'h0);

        // 5: rollover while holding '1' is ignored
        kv_base = kv_cnt;
        pressed[0] = 1'b1;
        wait_n(60);
        check("r1_kv", kv_cnt - kv_base, 1);
        check("r1_key", key, 4'h1);
        pressed[12] = 1'b1;
        wait_n(60);
        pressed[12] = 1'b0;
        wait_n(60);
        check("rA_kv", kv_cnt - kv_base, 1);
        check("rA_held", key_held, 1'b1);
        check("rA_key", key, 4'h1);
        pressed[0] = 1'b0;
        wait_n(70);
        kv_base = kv_cnt;
        pressed[3] = 1'b1;
        wait_n(60);
        check("r0_kv", kv_cnt - kv_base, 1);
        check("r0_key", key, 4'h0);
        check("r0_value", value, 32'h10);
        pressed[3] = 1'b0;
        wait_n(70);

        // 6a: clear held across the accept of '7'
        pressed[2] = 1'b1;
        clear = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 70) begin
            @(negedge clock);
            n++;
        end
        check("ca_kv_seen", key_valid, 1'b1);
        check("ca_value", value, 32'h0);
        check("ca_key", key, 4'h7);
        clear = 1'b0;
        pressed[2] = 1'b0;
        wait_n(70);
        tap(8);
        check("c3_value", value, 32'h3);

        // 6b: reset during DEB_PRESS of '8', then re-accept
        sync_scan();
        pressed[6] = 1'b1;
        wait_n(20);
        resetn = 1'b0;
        wait_n(2);
        check("mr_col", col, 4'b1110);
        check("mr_key", key, 4'h0);
        check("mr_kv", key_valid, 1'b0);
        check("mr_held", key_held, 1'b0);
        check("mr_value", value, 32'h0);
        kv_base = kv_cnt;
        resetn = 1'b1;
        wait_n(60);
        check("mr8_kv", kv_cnt - kv_base, 1);
        check("mr8_key", key, 4'h8);
        check("mr8_value", value, 32'h8);
        check("mr8_held", key_held, 1'b1);
        pressed[6] = 1'b0;
        wait_n(70);
        check("mr8_rel", key_held, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
